// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle restoring divider, WIDTH-bit operands, one
// quotient bit per clock. Signed operation works on magnitudes and fixes
// the signs in a final cycle. Divide-by-zero takes the same number of
// cycles as any other division and returns all-ones / the original dividend.
module div_seq_param #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dived,
  input  logic [WIDTH-1:0] divor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quoti,
  output logic [WIDTH-1:0] remai,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;        // partial remainder
  logic [WIDTH-1:0] sh;         // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;        // divisor magnitude
  logic [WIDTH-1:0] dived_raw;  // untouched dividend, returned on divide-by-zero
  logic [CW-1:0]    cnt;
  logic             qneg, rneg, dz;

  logic             smode;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign smode = sign_mode & (SIGNED_EN != 0);

  // The magnitude of the most negative value is its own bit pattern read
  // as unsigned, so no special case is needed for it.
  assign a_mag = (smode & dived[WIDTH-1]) ? -dived : dived;
  assign b_mag = (smode & divor[WIDTH-1]) ? -divor : divor;

  // Because rem < dvs is kept invariant, the shifted remainder is below
  // 2*dvs and bit WIDTH of the difference is a valid sign bit.
  assign trial = {rem, sh[WIDTH-1]} - {1'b0, dvs};

  assign q_fix = qneg ? -sh  : sh;
  assign r_fix = rneg ? -rem : rem;

  // Control FSM, datapath iteration and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem       <= '0;
      sh        <= '0;
      dvs       <= '0;
      dived_raw <= '0;
      cnt       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quoti     <= '0;
      remai     <= '0;
      div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dived_raw <= dived;
            dvs       <= b_mag;
            sh        <= a_mag;
            rem       <= '0;
            cnt       <= CW'(WIDTH-1);
            qneg      <= smode & (dived[WIDTH-1] ^ divor[WIDTH-1]);
            rneg      <= smode & dived[WIDTH-1];
            dz        <= (divor == '0);
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (trial[WIDTH]) rem <= {rem[WIDTH-2:0], sh[WIDTH-1]};
          else              rem <= trial[WIDTH-1:0];
          sh <= {sh[WIDTH-2:0], ~trial[WIDTH]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (dz) begin
            quoti <= '1;
            remai <= dived_raw;
            div0  <= 1'b1;
          end else begin
            quoti <= q_fix;
            remai <= r_fix;
            div0  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_seq_param.md
Name: div_seq_param

Overview:
- Parametrised multi-cycle restoring divider; successor to the fixed 32-bit unsigned sequential divider.
- Generalised to WIDTH bits, with a per-operation signed/unsigned mode.
- Adds a start/busy/done handshake, defined divide-by-zero results and held outputs.
- Sits beside the ALU as the DIV/DIVU/REM/REMU execution unit; produces one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SIGNED_EN, 1, 1 enables signed mode; 0 forces unsigned regardless of sign_mode.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low; asserting clears all state immediately.
- start  in  1  request a division; sampled only in IDLE.
- sign_mode  in  1  1 = signed two's-complement operands, 0 = unsigned; captured with start.
- dived  in  WIDTH  dividend; captured with start.
- divor  in  WIDTH  divisor; captured with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; results valid from this cycle.
- quoti  out  WIDTH  quotient, held until the next accepted start.
- remai  out  WIDTH  remainder, held until the next accepted start.
- div0  out  1  set with done when divor was zero; held with the results.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0, done=0, div0=0, quoti=0, remai=0; internal registers cleared. Deasserting rst resumes in IDLE on the next edge.
- Reset mid-operation aborts the division; no done pulse is produced for it.
- IDLE: when start=1 at a rising edge:
  - capture operands and the effective mode (smode = sign_mode & SIGNED_EN);
  - if smode, store magnitudes |dived| and |divor| as WIDTH-bit unsigned, plus sign flags qneg = dived_msb ^ divor_msb and rneg = dived_msb;
  - load the remainder register with 0 and the shift register with the dividend magnitude;
  - load the bit counter with WIDTH-1; go to CALC; busy=1.
- IDLE with start=0: outputs hold.
- CALC, one iteration per clock:
  - trial = {rem[WIDTH-1:0], shift_msb} minus divisor, computed WIDTH+1 bits wide;
  - if trial is non-negative: rem <= trial and quotient bit = 1; otherwise rem <= the shifted value and bit = 0;
  - quotient bits shift in LSB-first into the shift register;
  - when counter==0 go to FIX, otherwise decrement the counter.
  - CALC lasts exactly WIDTH cycles.
- FIX, one cycle:
  - apply sign correction: quoti = qneg ? -q : q; remai = rneg ? -r : r (signed only);
  - if divisor was 0, override: quoti = all ones, remai = original dived (unmodified two's-complement value), div0 = 1;
  - otherwise div0 = 0;
  - register the outputs, pulse done=1, busy=0, go to IDLE.
- Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH+1. Throughput is one division per WIDTH+2 cycles; back-to-back start is allowed in the done cycle.
- Signed overflow (dived = most negative, divor = -1): quoti = most negative value, remai = 0, div0 = 0. This falls out of the magnitude arithmetic; no special case is needed.
- start while busy: ignored; operands are not recaptured.
- Outputs only change in FIX or on reset; they are stable from done until the next FIX.
- Divide-by-zero uses the same latency as a normal division; there is no fast path.

Test Plan:
- WIDTH=32, unsigned: dived=100, divor=7 -> done 33 cycles after the start edge; quoti=14, remai=2, div0=0; busy high for exactly 33 cycles.
- WIDTH=32, signed: dived=-7 (0xFFFFFFF9), divor=2 -> quoti=-3 (0xFFFFFFFD), remai=-1 (0xFFFFFFFF). Same operands unsigned -> quoti=0x7FFFFFFC, remai=1.
- WIDTH=32, divide-by-zero: dived=0x12345678, divor=0 in each mode -> quoti=0xFFFFFFFF, remai=0x12345678, div0=1.
- WIDTH=32, signed overflow: dived=0x80000000, divor=0xFFFFFFFF -> quoti=0x80000000, remai=0, div0=0.
- WIDTH=8, SIGNED_EN=0, sign_mode=1: dived=0xF0, divor=0x10 -> quoti=0x0F, remai=0; done after 9 cycles.
- Handshake/reset: pulse start again mid-CALC -> ignored, results match the first operands. Assert rst low at cycle 5 of CALC -> busy=0, quoti=0 immediately, no done. Then start 50/5 -> quoti=10, remai=0.
